// File: rtl/rshift_rnd_sat_iq.sv
// rtl/rshift_rnd_sat_iq.sv - I/Q requantiser: programmable right shift, rounding, saturation
// Stage1 shifts and rounds at IN_W+1 bits; stage2 saturates to OUT_W and drives the output.
module rshift_rnd_sat_iq #(
  parameter int IN_W      = 17,
  parameter int OUT_W     = 13,
  parameter int SHIFT_MAX = 8,
  parameter int SH_W      = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SH_W-1:0]         cfg_shift,
  input  logic [1:0]              cfg_rnd,
  input  logic                    sat_clr,
  input  logic signed [IN_W-1:0]  in_data_i,
  input  logic signed [IN_W-1:0]  in_data_q,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data_i,
  output logic signed [OUT_W-1:0] out_data_q,
  output logic                    out_ovf_i,
  output logic                    out_ovf_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        sat_cnt_i,
  output logic [CNT_W-1:0]        sat_cnt_q
);

  localparam logic [SH_W-1:0]         K_MAX = SH_W'(SHIFT_MAX);
  localparam logic signed [IN_W:0]    R_MAX = (IN_W+1)'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0]    R_MIN = ~R_MAX;
  localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // h is the first discarded bit, t the OR of all bits below it
  function automatic logic signed [IN_W:0] requant(input logic signed [IN_W-1:0] x,
                                                   input logic [SH_W-1:0] k,
                                                   input logic [1:0] mode);
    logic signed [IN_W:0] q;
    logic h;
    logic t;
    logic inc;
    q = $signed({x[IN_W-1], x}) >>> k;
    h = 1'b0;
    t = 1'b0;
    for (int b = 0; b < SHIFT_MAX; b++) begin
      if (b + 1 == int'(k)) h = x[b];
      if (b + 1 < int'(k)) t = t | x[b];
    end
    case (mode)
      2'b01:   inc = h & (~x[IN_W-1] | t);
      2'b10:   inc = h & (t | q[0]);
      default: inc = 1'b0;
    endcase
    return q + $signed({{IN_W{1'b0}}, inc});
  endfunction

  // Packed result: {ovf, saturated value}
  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] r);
    if (r > R_MAX)      return {1'b1, Y_MAX};
    else if (r < R_MIN) return {1'b1, Y_MIN};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic                    adv;
  logic                    xfer;
  logic [SH_W-1:0]         k_eff;
  logic                    s1_valid_q;
  logic signed [IN_W:0]    s1_ri_q, s1_rq_q;
  logic signed [IN_W:0]    s1_ri_d, s1_rq_d;
  logic [OUT_W:0]          sat_i, sat_q;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_i_q, out_q_q;
  logic                    ovf_i_q, ovf_q_q;
  logic [CNT_W-1:0]        cnt_i_q, cnt_q_q, cnt_i_d, cnt_q_d;

  always_comb begin
    adv     = ~out_valid_q | out_ready;
    xfer    = out_valid_q & out_ready;
    k_eff   = (cfg_shift > K_MAX) ? K_MAX : cfg_shift;
    s1_ri_d = requant(in_data_i, k_eff, cfg_rnd);
    s1_rq_d = requant(in_data_q, k_eff, cfg_rnd);
    sat_i   = saturate(s1_ri_q);
    sat_q   = saturate(s1_rq_q);
    cnt_i_d = cnt_i_q;
    cnt_q_d = cnt_q_q;
    if (sat_clr) begin
      cnt_i_d = '0;
      cnt_q_d = '0;
    end else begin
      if (xfer && ovf_i_q && !(&cnt_i_q)) cnt_i_d = cnt_i_q + 1'b1;
      if (xfer && ovf_q_q && !(&cnt_q_q)) cnt_q_d = cnt_q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ri_q     <= '0;
      s1_rq_q     <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      ovf_i_q     <= 1'b0;
      ovf_q_q     <= 1'b0;
      cnt_i_q     <= '0;
      cnt_q_q     <= '0;
    end else begin
      if (adv) begin
        s1_valid_q  <= in_valid;
        s1_ri_q     <= s1_ri_d;
        s1_rq_q     <= s1_rq_d;
        out_valid_q <= s1_valid_q;
        // Empty output slots carry zero data
        out_i_q     <= s1_valid_q ? sat_i[OUT_W-1:0] : '0;
        out_q_q     <= s1_valid_q ? sat_q[OUT_W-1:0] : '0;
        ovf_i_q     <= s1_valid_q & sat_i[OUT_W];
        ovf_q_q     <= s1_valid_q & sat_q[OUT_W];
      end
      cnt_i_q <= cnt_i_d;
      cnt_q_q <= cnt_q_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_data_i = out_i_q;
  assign out_data_q = out_q_q;
  assign out_ovf_i  = ovf_i_q;
  assign out_ovf_q  = ovf_q_q;
  assign sat_cnt_i  = cnt_i_q;
  assign sat_cnt_q  = cnt_q_q;

endmodule

// File: tb/tb_rshift_rnd_sat_iq.sv
// tb/tb_rshift_rnd_sat_iq.sv - randomized and directed bench with arithmetic reference model
module tb_rshift_rnd_sat_iq;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         cfg_shift = '0;
  logic [1:0]         cfg_rnd = '0;
  logic               sat_clr = 1'b0;
  logic signed [16:0] in_data_i = '0, in_data_q = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [12:0] out_data_i, out_data_q;
  logic               out_ovf_i, out_ovf_q, out_valid;
  logic               out_ready = 1'b1;
  logic [15:0]        sat_cnt_i, sat_cnt_q;

  rshift_rnd_sat_iq dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_rnd(cfg_rnd), .sat_clr(sat_clr),
    .in_data_i(in_data_i), .in_data_q(in_data_q), .in_valid(in_valid), .in_ready(in_ready),
    .out_data_i(out_data_i), .out_data_q(out_data_q), .out_ovf_i(out_ovf_i),
    .out_ovf_q(out_ovf_q), .out_valid(out_valid), .out_ready(out_ready),
    .sat_cnt_i(sat_cnt_i), .sat_cnt_q(sat_cnt_q)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int q; int oi; int oq; } exp_t;
  exp_t sb[$];
  int   total = 0, bad = 0;
  int   ci = 0, cq = 0;
  bit   stall_prev = 0;
  int   prev_i, prev_q, prev_oi, prev_oq;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: floor quotient plus remainder comparison against half an LSB
  function automatic int ref_rnd(input int x, input int sh, input int mode);
    int k, p, q, frac;
    k = (sh > 8) ? 8 : sh;
    p = 1 << k;
    q = x >>> k;
    frac = x - q * p;
    if (mode == 1 && (2 * frac > p || (2 * frac == p && x >= 0))) q = q + 1;
    if (mode == 2 && (2 * frac > p || (2 * frac == p && (q % 2) != 0))) q = q + 1;
    return q;
  endfunction

  function automatic exp_t ref_model(input int xi, input int xq, input int sh, input int mode);
    exp_t e;
    int ri, rq;
    ri = ref_rnd(xi, sh, mode);
    rq = ref_rnd(xq, sh, mode);
    e.oi = (ri > 4095 || ri < -4096) ? 1 : 0;
    e.oq = (rq > 4095 || rq < -4096) ? 1 : 0;
    e.i  = (ri > 4095) ? 4095 : (ri < -4096) ? -4096 : ri;
    e.q  = (rq > 4095) ? 4095 : (rq < -4096) ? -4096 : rq;
    return e;
  endfunction

  task automatic drive(input bit v, input int xi, input int xq, input bit rdy,
                       input int sh, input int mode, input bit clr);
    in_valid  = v;
    in_data_i = 17'(xi);
    in_data_q = 17'(xq);
    out_ready = rdy;
    cfg_shift = 4'(sh);
    cfg_rnd   = 2'(mode);
    sat_clr   = clr;
  endtask

  // One clock: check outputs against the scoreboard, then advance past the edge
  task automatic step();
    exp_t e;
    bit   acc, xfer, popped;
    #1;
    chk("in_ready", in_ready, (!out_valid || out_ready));
    if (!out_valid) begin
      chk("idle_i", out_data_i, 0);
      chk("idle_q", out_data_q, 0);
    end
    if (stall_prev) begin
      chk("hold_v", out_valid, 1);
      chk("hold_i", $signed(out_data_i), prev_i);
      chk("hold_q", $signed(out_data_q), prev_q);
      chk("hold_oi", out_ovf_i, prev_oi);
      chk("hold_oq", out_ovf_q, prev_oq);
    end
    acc    = in_valid && in_ready;
    xfer   = out_valid && out_ready;
    popped = 0;
    if (xfer) begin
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = sb.pop_front();
        popped = 1;
        chk("data_i", $signed(out_data_i), e.i);
        chk("data_q", $signed(out_data_q), e.q);
        chk("ovf_i", out_ovf_i, e.oi);
        chk("ovf_q", out_ovf_q, e.oq);
      end
    end
    if (sat_clr) begin
      ci = 0;
      cq = 0;
    end else if (popped) begin
      if (e.oi != 0 && ci < 65535) ci++;
      if (e.oq != 0 && cq < 65535) cq++;
    end
    if (acc) sb.push_back(ref_model($signed(in_data_i), $signed(in_data_q),
                                    int'(cfg_shift), int'(cfg_rnd)));
    stall_prev = out_valid && !out_ready;
    prev_i  = $signed(out_data_i);
    prev_q  = $signed(out_data_q);
    prev_oi = out_ovf_i;
    prev_oq = out_ovf_q;
    @(posedge clk);
    #1;
    chk("cnt_i", sat_cnt_i, ci);
    chk("cnt_q", sat_cnt_q, cq);
  endtask

  task automatic rst_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ci = 0;
    cq = 0;
    stall_prev = 0;
  endtask

  task automatic single(input string tag, input int sh, input int mode, input int xi, input int xq,
                        input int ei, input int eq, input int eoi, input int eoq);
    int n;
    @(negedge clk);
    drive(1, xi, xq, 1, sh, mode, 0);
    step();
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      drive(0, 0, 0, 1, sh, mode, 0);
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_i"}, $signed(out_data_i), ei);
    chk({tag, "_q"}, $signed(out_data_q), eq);
    chk({tag, "_oi"}, out_ovf_i, eoi);
    chk({tag, "_oq"}, out_ovf_q, eoq);
    @(negedge clk);
    drive(0, 0, 0, 1, sh, mode, 0);
    step();
  endtask

  initial begin
    bit rdy_pat[12] = '{1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    int sent;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data_i", out_data_i, 0);
    chk("rst_ovf_i", out_ovf_i, 0);
    chk("rst_cnt_i", sat_cnt_i, 0);
    chk("rst_cnt_q", sat_cnt_q, 0);
    chk("rst_ready", in_ready, 1);

    single("m1a", 4, 1, 24, -56, 2, -4, 0, 0);
    single("m1b", 4, 1, -55, 23, -3, 1, 0, 0);
    single("m2a", 4, 2, 40, 56, 2, 4, 0, 0);
    single("m2b", 4, 2, -40, 8, -2, 0, 0, 0);
    single("m0", 4, 0, -1, 15, -1, 0, 0, 0);
    single("m3", 4, 3, 15, -1, 0, -1, 0, 0);
    single("k0", 0, 1, 100, -7, 100, -7, 0, 0);
    single("sat", 4, 1, 65528, -65536, 4095, -4096, 1, 0);
    chk("sat_cnt_i1", sat_cnt_i, 1);
    single("satq", 0, 0, 0, -65536, 0, -4096, 0, 1);
    chk("sat_cnt_q1", sat_cnt_q, 1);
    single("clamp", 15, 0, 256, -256, 1, -1, 0, 0);

    sent = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(sent < 6, 1000 * (sent + 1), -333 * (sent + 1), rdy_pat[c], 2, 1, 0);
      if (in_valid && in_ready) sent++;
      if (c == 3) chk("bp_in_ready_low", in_ready, 0);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 0);
      step();
    end
    chk("bp_sent", sent, 6);
    chk("bp_drained", sb.size(), 0);

    chk("pre_rst_cnt_nz", sat_cnt_i != 0, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1, 70000, -70000, 0, 0, 0, 0);
      step();
    end
    rst_dut();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt_i", sat_cnt_i, 0);
    chk("mid_rst_cnt_q", sat_cnt_q, 0);
    chk("mid_rst_ready", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 0);
      step();
    end

    for (int c = 0; c < 2000; c++) begin
      int x1, x2;
      x1 = $signed(17'($urandom));
      x2 = ($urandom_range(0, 3) == 0) ? -65536 : $signed(17'($urandom));
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, x1, x2, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 60) == 0);
      step();
    end

    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    step();
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      drive(1, 65535, -65536, 1, 0, 0, 0);
      step();
    end
    chk("cnt_stick_i", sat_cnt_i, 65535);
    chk("cnt_stick_q", sat_cnt_q, 65535);
    @(negedge clk);
    drive(1, 65535, -65536, 1, 0, 0, 1);
    chk("clr_with_xfer", out_valid && out_ovf_i, 1);
    step();
    chk("clr_pri_i", sat_cnt_i, 0);
    chk("clr_pri_q", sat_cnt_q, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 0);
      step();
    end
    chk("final_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
